uart_tx_buffered: RTL and testbench

//  Buffered 8N1 UART transmitter: the send-side counterpart to the UART receive path.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_buffered_if.sv | 26 ++
 rtl/uart_tx_fifo.sv | 58 +++++
 rtl/uart_tx_buffered.sv | 144 ++++++++++++++
 tb/tb_uart_tx_buffered.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

   // Serializer states: wait for data, then start bit, 8 data bits, stop bit.
   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_tx_state_t;

   // Start + 8 data + stop.
   localparam int UART_FRAME_BITS = 10;

   // 100 MHz system clock divided down to 115200 baud.
   localparam int UART_BAUD_DIV = 868;

   localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// CPU-side write/status bundle plus the serial line of the buffered UART transmitter.
interface uart_tx_buffered_if;
   import uart_pkg::*;

   logic                      wr_en;
   logic [UART_DATA_BITS-1:0] writedata;
   logic                      clr_overflow;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic                      tx_busy;
   logic                      overflow;
   logic                      tx_done;
   logic                      UART_TX;

   // The CPU store path drives writes and polls status.
   modport master (
      output wr_en, writedata, clr_overflow,
      input  fifo_full, fifo_empty, tx_busy, overflow, tx_done, UART_TX
   );

   // The transmitter consumes writes and reports status.
   modport slave (
      input  wr_en, writedata, clr_overflow,
      output fifo_full, fifo_empty, tx_busy, overflow, tx_done, UART_TX
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Small circular FIFO holding bytes waiting for the serializer.
// A push is accepted when there is room or when a pop frees a slot the same cycle.
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             sysclk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] pushData,
   input  logic             pop,
   output logic [WIDTH-1:0] popData,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wrPtr_q;
   logic [PW-1:0]    rdPtr_q;
   logic [PW:0]      count_q;
   logic             doPush;

   assign full    = (count_q == (PW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign doPush  = push && (!full || pop);
   assign popData = mem_q[rdPtr_q];

   // Storage array; contents are don't-care until written, so no reset needed.
   always_ff @(posedge sysclk) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= pushData;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         if (doPush && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !doPush) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO in front of a back-to-back frame serializer.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int BAUD_DIV   = UART_BAUD_DIV,
   parameter int FIFO_DEPTH = 4
) (
   input  logic         sysclk,
   input  logic         reset,
   uart_tx_buffered_if.slave bus
);

   localparam int                CW        = $clog2(BAUD_DIV);
   localparam logic [CW-1:0]     BAUD_LAST = CW'(BAUD_DIV - 1);

   uart_tx_state_t             state_q, state_d;
   logic [CW-1:0]              baudCnt_q, baudCnt_d;
   logic [2:0]                 bitIdx_q, bitIdx_d;
   logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
   logic                       txLine_q, txLine_d;
   logic                       overflow_q, overflow_d;
   logic                       pop;
   logic                       bitEnd;
   logic [UART_DATA_BITS-1:0]  popData;
   logic                       fifoFull;
   logic                       fifoEmpty;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .sysclk   (sysclk),
      .reset    (reset),
      .push     (bus.wr_en),
      .pushData (bus.writedata),
      .pop      (pop),
      .popData  (popData),
      .full     (fifoFull),
      .empty    (fifoEmpty)
   );

   assign bitEnd = (baudCnt_q == BAUD_LAST);

   // Next-state logic: advance through the frame, popping the next byte at idle or stop end.
   always_comb begin
      state_d   = state_q;
      baudCnt_d = baudCnt_q;
      bitIdx_d  = bitIdx_q;
      shift_d   = shift_q;
      txLine_d  = txLine_q;
      pop       = 1'b0;
      unique case (state_q)
         IDLE: begin
            txLine_d  = 1'b1;
            baudCnt_d = '0;
            if (!fifoEmpty) begin
               pop      = 1'b1;
               shift_d  = popData;
               txLine_d = 1'b0;
               state_d  = START;
            end
         end
         START: begin
            baudCnt_d = baudCnt_q + 1'b1;
            if (bitEnd) begin
               baudCnt_d = '0;
               bitIdx_d  = '0;
               txLine_d  = shift_q[0];
               state_d   = DATA;
            end
         end
         DATA: begin
            baudCnt_d = baudCnt_q + 1'b1;
            if (bitEnd) begin
               baudCnt_d = '0;
               if (bitIdx_q == 3'd7) begin
                  txLine_d = 1'b1;
                  state_d  = STOP;
               end else begin
                  shift_d  = shift_q >> 1;
                  txLine_d = shift_q[1];
                  bitIdx_d = bitIdx_q + 3'd1;
               end
            end
         end
         STOP: begin
            baudCnt_d = baudCnt_q + 1'b1;
            if (bitEnd) begin
               baudCnt_d = '0;
               if (!fifoEmpty) begin
                  pop      = 1'b1;
                  shift_d  = popData;
                  txLine_d = 1'b0;
                  state_d  = START;
               end else begin
                  txLine_d = 1'b1;
                  state_d  = IDLE;
               end
            end
         end
         default: begin
            state_d  = IDLE;
            txLine_d = 1'b1;
         end
      endcase
   end

   // A write is lost only when the FIFO is full and no pop frees a slot; a new drop beats a clear.
   always_comb begin
      overflow_d = overflow_q;
      if (bus.wr_en && fifoFull && !pop) begin
         overflow_d = 1'b1;
      end else if (bus.clr_overflow) begin
         overflow_d = 1'b0;
      end
   end

   // Serializer and status registers.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         state_q    <= IDLE;
         baudCnt_q  <= '0;
         bitIdx_q   <= '0;
         shift_q    <= '0;
         txLine_q   <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         baudCnt_q  <= baudCnt_d;
         bitIdx_q   <= bitIdx_d;
         shift_q    <= shift_d;
         txLine_q   <= txLine_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.UART_TX    = txLine_q;
   assign bus.tx_busy    = (state_q != IDLE);
   assign bus.tx_done    = (state_q == STOP) && bitEnd;
   assign bus.overflow   = overflow_q;
   assign bus.fifo_full  = fifoFull;
   assign bus.fifo_empty = fifoEmpty;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Testbench for uart_tx_buffered with a frame-level reference model.
module tb_uart_tx_buffered;
   import uart_pkg::*;

   localparam int BD    = 4;
   localparam int DEPTH = 4;
   localparam int FL    = UART_FRAME_BITS * BD;

   logic sysclk = 1'b0;
   logic reset  = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   uart_tx_buffered_if bus ();

   uart_tx_buffered #(
      .BAUD_DIV   (BD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .sysclk (sysclk),
      .reset  (reset),
      .bus    (bus)
   );

   // Free-running system clock.
   always #5 sysclk = ~sysclk;

   // Reference model: a queue of pending bytes plus the cycle offset into the frame on the line.
   logic [7:0] mq [$];
   logic [7:0] cur = 8'h00;
   int         fc = -1;
   logic       movf = 1'b0;

   // Model update on every rising edge, from the inputs the bench is holding.
   always @(posedge sysclk) begin : model
      bit popNow;
      bit acc;
      if (reset) begin
         mq.delete();
         fc   = -1;
         movf = 1'b0;
      end else begin
         popNow = (fc == -1 || fc == FL - 1) && (mq.size() > 0);
         acc    = bus.wr_en && (mq.size() < DEPTH || popNow);
         if (bus.wr_en && !acc) movf = 1'b1;
         else if (bus.clr_overflow) movf = 1'b0;
         if (popNow) begin
            cur = mq.pop_front();
            fc  = 0;
         end else if (fc == FL - 1) begin
            fc = -1;
         end else if (fc >= 0) begin
            fc++;
         end
         if (acc) mq.push_back(bus.writedata);
      end
   end

   // Expected {UART_TX, tx_done, tx_busy, fifo_full, fifo_empty, overflow} from model state.
   function automatic logic [5:0] expVec();
      int   n;
      logic line;
      if (fc < 0) begin
         line = 1'b1;
      end else begin
         n = fc / BD;
         if (n == 0)      line = 1'b0;
         else if (n == 9) line = 1'b1;
         else             line = cur[n-1];
      end
      return {line, (fc == FL - 1), (fc >= 0), (mq.size() == DEPTH), (mq.size() == 0), movf};
   endfunction

   // Drive one cycle of inputs, then land on the following falling edge for sampling.
   task automatic tick(input logic w, input logic [7:0] d, input logic c);
      bus.wr_en        = w;
      bus.writedata    = d;
      bus.clr_overflow = c;
      @(posedge sysclk);
      @(negedge sysclk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.wr_en = 1'b0;
      bus.writedata = 8'h00;
      bus.clr_overflow = 1'b0;
      repeat (3) @(posedge sysclk);
      @(negedge sysclk);
      vectors++;
      if (bus.UART_TX !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_tx got %b want 1", bus.UART_TX); end
      vectors++;
      if (bus.fifo_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_empty got %b want 1", bus.fifo_empty); end
      vectors++;
      if (bus.fifo_full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_full got %b want 0", bus.fifo_full); end
      vectors++;
      if (bus.tx_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", bus.tx_busy); end
      vectors++;
      if (bus.overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ovf got %b want 0", bus.overflow); end
      vectors++;
      if (bus.tx_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", bus.tx_done); end
      reset = 1'b0;
   endtask

   task automatic test_single_frame();
      logic [5:0] got;
      int doneCnt = 0;
      tick(1'b1, 8'hA5, 1'b0);
      vectors++;
      if (bus.UART_TX !== 1'b1) begin miscompares++; $display("[TB] FAIL single_store_edge tx got %b want 1", bus.UART_TX); end
      for (int i = 0; i < FL + 5; i++) begin
         tick(1'b0, 8'h00, 1'b0);
         if (bus.tx_done === 1'b1) doneCnt++;
         if (i == 0) begin
            vectors++;
            if (bus.UART_TX !== 1'b0) begin miscompares++; $display("[TB] FAIL single_start_fall tx got %b want 0", bus.UART_TX); end
         end
         got = {bus.UART_TX, bus.tx_done, bus.tx_busy, bus.fifo_full, bus.fifo_empty, bus.overflow};
         vectors++;
         if (got !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL single_frame cyc %0d got %b want %b (tx,done,busy,full,empty,ovf)", i, got, expVec());
         end
      end
      vectors++;
      if (doneCnt !== 1) begin miscompares++; $display("[TB] FAIL single_done_count got %0d want 1", doneCnt); end
   endtask

   task automatic test_back_to_back();
      logic [5:0] got;
      int doneCnt = 0;
      int idleCnt = 0;
      tick(1'b1, 8'h55, 1'b0);
      tick(1'b1, 8'h0F, 1'b0);
      for (int i = 0; i < 2 * FL + 8; i++) begin
         if (bus.tx_done === 1'b1) doneCnt++;
         if (i < 2 * FL - 1 && bus.tx_busy !== 1'b1) idleCnt++;
         got = {bus.UART_TX, bus.tx_done, bus.tx_busy, bus.fifo_full, bus.fifo_empty, bus.overflow};
         vectors++;
         if (got !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL back_to_back cyc %0d got %b want %b (tx,done,busy,full,empty,ovf)", i, got, expVec());
         end
         tick(1'b0, 8'h00, 1'b0);
      end
      vectors++;
      if (doneCnt !== 2) begin miscompares++; $display("[TB] FAIL b2b_done_count got %0d want 2", doneCnt); end
      vectors++;
      if (idleCnt !== 0) begin miscompares++; $display("[TB] FAIL b2b_gap idle cycles got %0d want 0", idleCnt); end
   endtask

   task automatic test_overflow();
      logic [5:0] got;
      int doneCnt = 0;
      for (int b = 1; b <= 6; b++) begin
         tick(1'b1, 8'(b), 1'b0);
         got = {bus.UART_TX, bus.tx_done, bus.tx_busy, bus.fifo_full, bus.fifo_empty, bus.overflow};
         vectors++;
         if (got !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL overflow_fill byte %0d got %b want %b (tx,done,busy,full,empty,ovf)", b, got, expVec());
         end
      end
      vectors++;
      if (bus.overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL overflow_set got %b want 1", bus.overflow); end
      vectors++;
      if (bus.fifo_full !== 1'b1) begin miscompares++; $display("[TB] FAIL overflow_full got %b want 1", bus.fifo_full); end
      tick(1'b0, 8'h00, 1'b1);
      vectors++;
      if (bus.overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL overflow_clear got %b want 0", bus.overflow); end
      for (int i = 0; i < 5 * FL + 10; i++) begin
         tick(1'b0, 8'h00, 1'b0);
         if (bus.tx_done === 1'b1) doneCnt++;
         got = {bus.UART_TX, bus.tx_done, bus.tx_busy, bus.fifo_full, bus.fifo_empty, bus.overflow};
         vectors++;
         if (got !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL overflow_drain cyc %0d got %b want %b (tx,done,busy,full,empty,ovf)", i, got, expVec());
         end
      end
      vectors++;
      if (doneCnt !== 5) begin miscompares++; $display("[TB] FAIL overflow_frames got %0d want 5", doneCnt); end
   endtask

   task automatic test_full_pop_write();
      logic [5:0] got;
      int   waited = 0;
      for (int b = 0; b < 5; b++) tick(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      while (bus.tx_done !== 1'b1 && waited < 100) begin
         tick(1'b0, 8'h00, 1'b0);
         waited++;
         got = {bus.UART_TX, bus.tx_done, bus.tx_busy, bus.fifo_full, bus.fifo_empty, bus.overflow};
         vectors++;
         if (got !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL full_wait cyc %0d got %b want %b (tx,done,busy,full,empty,ovf)", waited, got, expVec());
         end
      end
      vectors++;
      if (waited >= 100) begin miscompares++; $display("[TB] FAIL full_wait_timeout waited %0d want <100", waited); end
      tick(1'b1, 8'h77, 1'b0);
      vectors++;
      if (bus.overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL full_pop_ovf got %b want 0", bus.overflow); end
      vectors++;
      if (bus.fifo_full !== 1'b1) begin miscompares++; $display("[TB] FAIL full_pop_count full got %b want 1", bus.fifo_full); end
      for (int i = 0; i < 4 * FL + 10; i++) begin
         tick(1'b0, 8'h00, 1'b0);
         got = {bus.UART_TX, bus.tx_done, bus.tx_busy, bus.fifo_full, bus.fifo_empty, bus.overflow};
         vectors++;
         if (got !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL full_drain cyc %0d got %b want %b (tx,done,busy,full,empty,ovf)", i, got, expVec());
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic [5:0] got;
      int waited = 0;
      int doneCnt = 0;
      tick(1'b1, 8'hC3, 1'b0);
      tick(1'b1, 8'h99, 1'b0);
      while (fc != 4 * BD + 1 && waited < 100) begin
         tick(1'b0, 8'h00, 1'b0);
         waited++;
      end
      vectors++;
      if (waited >= 100) begin miscompares++; $display("[TB] FAIL midframe_wait_timeout waited %0d want <100", waited); end
      reset = 1'b1;
      tick(1'b0, 8'h00, 1'b0);
      reset = 1'b0;
      vectors++;
      if (bus.UART_TX !== 1'b1) begin miscompares++; $display("[TB] FAIL midframe_tx got %b want 1", bus.UART_TX); end
      vectors++;
      if (bus.fifo_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL midframe_empty got %b want 1", bus.fifo_empty); end
      vectors++;
      if (bus.tx_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midframe_busy got %b want 0", bus.tx_busy); end
      tick(1'b1, 8'h3C, 1'b0);
      for (int i = 0; i < FL + 5; i++) begin
         tick(1'b0, 8'h00, 1'b0);
         if (bus.tx_done === 1'b1) doneCnt++;
         got = {bus.UART_TX, bus.tx_done, bus.tx_busy, bus.fifo_full, bus.fifo_empty, bus.overflow};
         vectors++;
         if (got !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL midframe_resend cyc %0d got %b want %b (tx,done,busy,full,empty,ovf)", i, got, expVec());
         end
      end
      vectors++;
      if (doneCnt !== 1) begin miscompares++; $display("[TB] FAIL midframe_done_count got %0d want 1", doneCnt); end
   endtask

   task automatic test_random();
      logic [5:0] got;
      for (int i = 0; i < 1500; i++) begin
         reset = ($urandom_range(0, 399) == 0);
         tick(($urandom_range(0, 9) < 2), 8'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0));
         got = {bus.UART_TX, bus.tx_done, bus.tx_busy, bus.fifo_full, bus.fifo_empty, bus.overflow};
         vectors++;
         if (got !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL random cyc %0d got %b want %b (tx,done,busy,full,empty,ovf)", i, got, expVec());
         end
      end
      reset = 1'b0;
      for (int i = 0; i < (DEPTH + 1) * FL + 10; i++) begin
         tick(1'b0, 8'h00, 1'b0);
         got = {bus.UART_TX, bus.tx_done, bus.tx_busy, bus.fifo_full, bus.fifo_empty, bus.overflow};
         vectors++;
         if (got !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL random_drain cyc %0d got %b want %b (tx,done,busy,full,empty,ovf)", i, got, expVec());
         end
      end
   endtask

   // Scenario sequence followed by the summary.
   initial begin
      bus.wr_en = 1'b0;
      bus.writedata = 8'h00;
      bus.clr_overflow = 1'b0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_overflow();
      test_full_pop_write();
      test_reset_midframe();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
